priority_decoder: RTL
=====================

PRIORITY_DECODER -- requirements
Module: prioritydecoder

Interface
REQ-001 SHALL have parameter SIZE, default 5: index width; decoded vector width is 2**SIZE (32 at default).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid_i  input  1  request present.
REQ-005 SHALL have port in_ready_o  output  1  block can accept a request this cycle.
REQ-006 SHALL have port idx_i  input  SIZE  index to decode.
REQ-007 SHALL have port nz_i  input  1  index meaningful; 0 means "no bit set" (encoder-side valid).
REQ-008 SHALL have port out_valid_o  output  1  decoded result present.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts result this cycle.
REQ-010 SHALL have port onehot_o  output  2**SIZE  one-hot decode of head entry.
REQ-011 SHALL have port mask_o  output  2**SIZE  thermometer of head entry: bits [idx:0] set.
REQ-012 SHALL have port accum_o  output  2**SIZE  OR of all delivered one-hot results since last clear.
REQ-013 SHALL have port clr_i  input  1  synchronous clear of accum_o.

Function
REQ-014 Input handshake SHALL occur on a rising edge where in_valid_i and in_ready_o are both 1; output handshake where out_valid_o and out_ready_i are both 1.
REQ-015 SHALL buffer accepted requests in a 2-entry FIFO, in order, storing {nz_i, idx_i} only; no drops, no duplicates.
REQ-016 in_ready_o SHALL be 1 when occupancy < 2 and rst_i is 0; it SHALL NOT depend combinationally on out_ready_i.
REQ-017 Latency SHALL be 1 cycle: request accepted at edge N into an empty FIFO gives out_valid_o = 1 immediately after edge N.
REQ-018 out_valid_o SHALL be 1 exactly when occupancy > 0; onehot_o, mask_o reflect the head entry and hold stable while out_valid_o = 1 and out_ready_i = 0.
REQ-019 For head with nz = 1: onehot_o bit idx = 1, all others 0; mask_o bits 0..idx = 1, above idx = 0.
REQ-020 For head with nz = 0: onehot_o = 0 and mask_o = 0; entry still handshakes normally.
REQ-021 When out_valid_o = 0, onehot_o and mask_o SHALL be 0.
REQ-022 Occupancy update: push only -> +1; pop only -> -1; push and pop same edge (occupancy 1) -> unchanged, new entry becomes head; occupancy 2 -> no push possible.
REQ-023 Occupancy SHALL never exceed 2 nor underflow; a pop with occupancy 0 cannot occur since out_valid_o = 0.
REQ-024 accum_o next value SHALL be (clr_i ? 0 : accum_o) OR (output handshake ? onehot_o : 0); delivered bit on a clear edge survives.
REQ-025 idx_i SHALL be fully decoded for every SIZE-bit value; no out-of-range case exists.

Reset
REQ-026 While rst_i = 1, regardless of clock: occupancy = 0, out_valid_o = 0, in_ready_o = 0, onehot_o = 0, mask_o = 0, accum_o = 0.
REQ-027 First rising edge after rst_i deasserts SHALL be able to accept a request (in_ready_o = 1).
REQ-028 Reset mid-operation SHALL discard buffered entries and accum_o; no partial result emerges afterward.

Verification
REQ-029 Single push idx=5, nz=1, out_ready_i=1 -> next cycle out_valid_o=1, onehot_o=0x00000020, mask_o=0x0000003F; after pop accum_o=0x00000020.
REQ-030 out_ready_i=0, push idx=31 then idx=0 -> in_ready_o=0 after second push; third request stalled; release -> outputs 0x80000000 then 0x00000001 in order.
REQ-031 Push nz=0, idx=7 -> onehot_o=0, mask_o=0, out_valid_o=1 one cycle, accum_o unchanged.
REQ-032 Occupancy 1, simultaneous push idx=3 and pop -> occupancy stays 1, next head onehot_o=0x00000008.
REQ-033 accum_o=0x00000020, clr_i=1 same edge as delivering idx=2 -> accum_o=0x00000004.
REQ-034 FIFO full, assert rst_i asynchronously mid-cycle -> out_valid_o, onehot_o, accum_o go 0 before next edge; after release, no stale output.

Source files
------------

// File: rtl/priority_decoder.sv
// Priority decoder: buffers {nz, idx} requests in a 2-entry FIFO and
// presents the head as a one-hot vector, a thermometer mask and a
// running OR of every delivered one-hot result.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   request present
//   in_ready_o   a request can be accepted this cycle
//   idx_i        index to decode (SIZE bits)
//   nz_i         index meaningful; 0 means "no bit set"
//   out_valid_o  decoded head entry present
//   out_ready_i  consumer takes the head entry this cycle
//   onehot_o     one-hot decode of the head entry
//   mask_o       thermometer of the head entry, bits [idx:0] set
//   accum_o      OR of all delivered one-hot results since last clear
//   clr_i        synchronous clear of accum_o
module priority_decoder #(
    parameter int SIZE = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [SIZE-1:0]      idx_i,
    input  logic                 nz_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2**SIZE-1:0]   onehot_o,
    output logic [2**SIZE-1:0]   mask_o,
    output logic [2**SIZE-1:0]   accum_o,
    input  logic                 clr_i
);

    localparam int W = 2**SIZE;

    // Entry layout: {nz, idx}
    logic [1:0]    count_q, count_d;
    logic [SIZE:0] head_q, head_d;
    logic [SIZE:0] tail_q, tail_d;
    logic [W-1:0]  accum_q, accum_d;

    logic [SIZE:0] in_entry;
    logic          push;
    logic          pop;

    // Ready looks only at occupancy, never at out_ready_i.
    assign in_ready_o  = !rst_i && (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign in_entry    = {nz_i, idx_i};
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign accum_o     = accum_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = in_entry;
                end else begin
                    tail_d = in_entry;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Push implies occupancy 1 here, so the new entry
                // replaces the departing head directly.
                head_d = in_entry;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        onehot_o = '0;
        mask_o   = '0;
        for (int i = 0; i < W; i++) begin
            if (out_valid_o && head_q[SIZE]) begin
                onehot_o[i] = (i[SIZE-1:0] == head_q[SIZE-1:0]);
                mask_o[i]   = (i[SIZE-1:0] <= head_q[SIZE-1:0]);
            end
        end
    end

    // A bit delivered on the same edge as a clear survives the clear.
    always_comb begin
        accum_d = (clr_i ? '0 : accum_q) | (pop ? onehot_o : '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
            accum_q <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            accum_q <= accum_d;
        end
    end

endmodule
